// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, jump, multi-cycle-unit and memory-freeze control
//
// Purpose: generates per-stage hold/flush controls, fetch redirect and the
// multi-cycle unit (MDU) handshake for a 5-stage in-order pipeline.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   hazard_hold_i         load-use hazard (same cycle)
//   jump_ena_i/addr_i     taken branch/jump resolved in EX and its target
//   mdu_start_i           EX holds a multi-cycle mul/div
//   mdu_done_i            MDU result valid (one-cycle pulse)
//   mem_wait_i            data memory not ready, freeze the pipe
//   *_hold_o              stage register hold
//   *_flush_o             stage register bubble insert
//   pc_jump_o/addr_o      fetch redirect (addr is 0 when no redirect)
//   mdu_go_o              one-cycle MDU launch pulse
//   mdu_err_o             sticky MDU timeout flag
//   stall_cnt_o           saturating count of cycles with pc_hold_o=1

module pipe_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_hold_i,
  input  logic              jump_ena_i,
  input  logic [31:0]       jump_addr_i,
  input  logic              mdu_start_i,
  input  logic              mdu_done_i,
  input  logic              mem_wait_i,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              id_ex_hold_o,
  output logic              ex_mem_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_flush_o,
  output logic              mem_wb_flush_o,
  output logic              pc_jump_o,
  output logic [31:0]       pc_jump_addr_o,
  output logic              mdu_go_o,
  output logic              mdu_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int TW = (MDU_TIMEOUT < 2) ? 1 : $clog2(MDU_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MDU_TIMEOUT - 1);

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  state_t          state, state_n;
  logic            done_pend, done_pend_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic            err_q;
  logic            tmo_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      done_pend   <= 1'b0;
      tmo         <= '0;
      err_q       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state     <= state_n;
      done_pend <= done_pend_n;
      tmo       <= tmo_n;
      err_q     <= err_q | tmo_fire;
      if (pc_hold_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  // The timeout is flagged in the same cycle the pipe is released so that
  // software sees the error together with the (invalid) result advancing.
  assign mdu_err_o = err_q | tmo_fire;

  always_comb begin
    state_n        = state;
    done_pend_n    = done_pend;
    tmo_n          = tmo;
    tmo_fire       = 1'b0;
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    id_ex_hold_o   = 1'b0;
    ex_mem_hold_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    mem_wb_flush_o = 1'b0;
    pc_jump_o      = 1'b0;
    pc_jump_addr_o = 32'h0;
    mdu_go_o       = 1'b0;

    if (mem_wait_i) begin
      // Whole pipe frozen; a done pulse that lands here must not be lost.
      pc_hold_o      = 1'b1;
      if_id_hold_o   = 1'b1;
      id_ex_hold_o   = 1'b1;
      ex_mem_hold_o  = 1'b1;
      mem_wb_flush_o = 1'b1;
      if ((state == MDU) && mdu_done_i)
        done_pend_n = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mdu_start_i) begin
            mdu_go_o       = 1'b1;
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_hold_o   = 1'b1;
            ex_mem_flush_o = 1'b1;
            tmo_n          = '0;
            state_n        = MDU;
          end else if (jump_ena_i) begin
            pc_jump_o      = 1'b1;
            pc_jump_addr_o = jump_addr_i;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
          end else if (hazard_hold_i) begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_flush_o = 1'b1;
          end
        end
        MDU: begin
          if (mdu_done_i || done_pend) begin
            state_n     = RUN;
            done_pend_n = 1'b0;
          end else if (tmo == TMO_LAST) begin
            tmo_fire = 1'b1;
            state_n  = RUN;
          end else begin
            pc_hold_o      = 1'b1;
            if_id_hold_o   = 1'b1;
            id_ex_hold_o   = 1'b1;
            ex_mem_flush_o = 1'b1;
            tmo_n          = tmo + TW'(1);
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard_hold_i, jump_ena_i, mdu_start_i, mdu_done_i, mem_wait_i;
  logic [31:0] jump_addr_i;
  logic        pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_mem_hold_o;
  logic        if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o;
  logic        pc_jump_o, mdu_go_o, mdu_err_o;
  logic [31:0] pc_jump_addr_o;
  logic [3:0]  stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_jump, mdu_go}
  logic [9:0] ctl;
  assign ctl = {pc_hold_o, if_id_hold_o, id_ex_hold_o, ex_mem_hold_o,
                if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
                pc_jump_o, mdu_go_o};

  localparam logic [9:0] C_IDLE  = 10'b0000_0000_00;
  localparam logic [9:0] C_HAZ   = 10'b1100_0100_00;
  localparam logic [9:0] C_JMP   = 10'b0000_1100_10;
  localparam logic [9:0] C_START = 10'b1110_0010_01;
  localparam logic [9:0] C_MDUW  = 10'b1110_0010_00;
  localparam logic [9:0] C_FRZ   = 10'b1111_0001_00;

  pipe_ctrl #(.MDU_TIMEOUT(8), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard_hold_i  (hazard_hold_i),
    .jump_ena_i     (jump_ena_i),
    .jump_addr_i    (jump_addr_i),
    .mdu_start_i    (mdu_start_i),
    .mdu_done_i     (mdu_done_i),
    .mem_wait_i     (mem_wait_i),
    .pc_hold_o      (pc_hold_o),
    .if_id_hold_o   (if_id_hold_o),
    .id_ex_hold_o   (id_ex_hold_o),
    .ex_mem_hold_o  (ex_mem_hold_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_flush_o (ex_mem_flush_o),
    .mem_wb_flush_o (mem_wb_flush_o),
    .pc_jump_o      (pc_jump_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .mdu_go_o       (mdu_go_o),
    .mdu_err_o      (mdu_err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    hazard_hold_i = 1'b0;
    jump_ena_i    = 1'b0;
    jump_addr_i   = 32'h0;
    mdu_start_i   = 1'b0;
    mdu_done_i    = 1'b0;
    mem_wait_i    = 1'b0;
  endtask

  // Next cycle: inputs change at the falling edge, checks run 1 time unit later.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    nxt();
    #1;
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_err", 32'(mdu_err_o), 32'd0);
    chk("reset_stall", 32'(stall_cnt_o), 32'd0);
    chk("reset_addr", pc_jump_addr_o, 32'h0);
    nxt();
    rst_n = 1'b1;

    // idle, with a stray target on the bus: address must stay 0
    nxt();
    jump_addr_i = 32'hDEAD_BEEF;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
    chk("idle_addr", pc_jump_addr_o, 32'h0);

    // load-use for one cycle
    nxt();
    clr_in();
    hazard_hold_i = 1'b1;
    #1;
    chk("haz_ctl", 32'(ctl), 32'(C_HAZ));
    nxt();
    hazard_hold_i = 1'b0;
    #1;
    chk("haz_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("haz_stall", 32'(stall_cnt_o), 32'd1);

    // jump beats hazard
    nxt();
    jump_ena_i    = 1'b1;
    jump_addr_i   = 32'h0000_0100;
    hazard_hold_i = 1'b1;
    #1;
    chk("jmp_ctl", 32'(ctl), 32'(C_JMP));
    chk("jmp_addr", pc_jump_addr_o, 32'h100);
    nxt();
    clr_in();
    #1;
    chk("jmp_stall", 32'(stall_cnt_o), 32'd1);

    // freeze in RUN blocks launch and jump; state stays RUN
    nxt();
    mem_wait_i  = 1'b1;
    mdu_start_i = 1'b1;
    jump_ena_i  = 1'b1;
    jump_addr_i = 32'h0000_0200;
    #1;
    chk("frz_run_ctl", 32'(ctl), 32'(C_FRZ));
    chk("frz_run_addr", pc_jump_addr_o, 32'h0);
    nxt();
    mem_wait_i = 1'b0;
    jump_ena_i = 1'b0;
    #1;
    chk("frz_run_launch", 32'(ctl), 32'(C_START));

    // MDU start at 0, done at 5
    do_reset();
    nxt();
    mdu_start_i = 1'b1;
    #1;
    chk("mdu_c0", 32'(ctl), 32'(C_START));
    for (int c = 1; c <= 4; c++) begin
      nxt();
      jump_ena_i    = (c == 2);
      jump_addr_i   = 32'h0000_0300;
      hazard_hold_i = (c == 3);
      #1;
      chk($sformatf("mdu_c%0d", c), 32'(ctl), 32'(C_MDUW));
    end
    nxt();
    clr_in();
    mdu_done_i = 1'b1;
    #1;
    chk("mdu_c5_release", 32'(ctl), 32'(C_IDLE));
    nxt();
    #1;
    chk("mdu_c6_ctl", 32'(ctl), 32'(C_IDLE));
    chk("mdu_stall", 32'(stall_cnt_o), 32'd5);
    // done in RUN is ignored: hazard still behaves as RUN afterwards
    nxt();
    mdu_done_i    = 1'b1;
    hazard_hold_i = 1'b1;
    #1;
    chk("done_in_run", 32'(ctl), 32'(C_HAZ));

    // freeze over done
    do_reset();
    nxt();
    mdu_start_i = 1'b1;
    #1;
    chk("fod_c0", 32'(ctl), 32'(C_START));
    for (int c = 1; c <= 6; c++) begin
      nxt();
      mdu_start_i = 1'b0;
      mem_wait_i  = (c >= 3);
      mdu_done_i  = (c == 4);
      #1;
      chk($sformatf("fod_c%0d", c), 32'(ctl), (c >= 3) ? 32'(C_FRZ) : 32'(C_MDUW));
    end
    nxt();
    clr_in();
    #1;
    chk("fod_c7_release", 32'(ctl), 32'(C_IDLE));
    nxt();
    mdu_start_i = 1'b1;
    #1;
    chk("fod_c8_run", 32'(ctl), 32'(C_START));
    chk("fod_stall", 32'(stall_cnt_o), 32'd7);

    // timeout (MDU_TIMEOUT=8)
    do_reset();
    nxt();
    mdu_start_i = 1'b1;
    #1;
    chk("tmo_c0", 32'(ctl), 32'(C_START));
    for (int c = 1; c <= 7; c++) begin
      nxt();
      mdu_start_i = 1'b0;
      #1;
      chk($sformatf("tmo_c%0d_ctl", c), 32'(ctl), 32'(C_MDUW));
    end
    chk("tmo_c7_err", 32'(mdu_err_o), 32'd0);
    nxt();
    #1;
    chk("tmo_c8_err", 32'(mdu_err_o), 32'd1);
    chk("tmo_c8_ctl", 32'(ctl), 32'(C_IDLE));
    nxt();
    nxt();
    #1;
    chk("tmo_sticky", 32'(mdu_err_o), 32'd1);
    chk("tmo_stall", 32'(stall_cnt_o), 32'd8);
    rst_n = 1'b0;
    #1;
    chk("tmo_rst_err", 32'(mdu_err_o), 32'd0);
    chk("tmo_rst_stall", 32'(stall_cnt_o), 32'd0);
    nxt();
    rst_n = 1'b1;

    // reset mid-MDU abandons the operation
    nxt();
    mdu_start_i = 1'b1;
    nxt();
    mdu_start_i = 1'b0;
    #1;
    chk("rmid_in_mdu", 32'(ctl), 32'(C_MDUW));
    rst_n = 1'b0;
    #1;
    chk("rmid_rst_ctl", 32'(ctl), 32'(C_IDLE));
    nxt();
    rst_n = 1'b1;
    nxt();
    hazard_hold_i = 1'b1;
    #1;
    chk("rmid_run", 32'(ctl), 32'(C_HAZ));

    // stall counter saturation (CNT_W=4)
    do_reset();
    hazard_hold_i = 1'b1;
    for (int c = 0; c < 20; c++) nxt();
    hazard_hold_i = 1'b0;
    #1;
    chk("stall_sat", 32'(stall_cnt_o), 32'd15);
    nxt();
    #1;
    chk("stall_sat_hold", 32'(stall_cnt_o), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
